// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg : shared widths and mul/div sequencer state encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int RegAddrWidth = 5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect : load-use comparator between ID and EX
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RegAddrW = RegAddrWidth
) (
  input  logic [RegAddrW-1:0] id_rs_addr,
  input  logic [RegAddrW-1:0] id_rt_addr,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_ReadMem,
  input  logic                ex_WriteReg,
  input  logic [RegAddrW-1:0] ex_dest,
  output logic                o_luh
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = id_uses_rs && (id_rs_addr == ex_dest);
  assign w_rt_hit = id_uses_rt && (id_rt_addr == ex_dest);
  // $zero is never a real producer, so a load targeting it cannot hazard
  assign o_luh    = ex_ReadMem && ex_WriteReg && (ex_dest != '0) && (w_rs_hit || w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : pipeline stall/flush sequencing and mul/div hold control
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RegAddrW  = RegAddrWidth,
  parameter int MD_CYCLES = 32,
  parameter int MD_CW     = 6,
  parameter int STALL_CW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] id_rs_addr,
  input  logic [RegAddrW-1:0] id_rt_addr,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_muldiv,
  input  logic                ex_ReadMem,
  input  logic                ex_WriteReg,
  input  logic [RegAddrW-1:0] ex_dest,
  input  logic                br_taken,
  input  logic                mem_stall,
  output logic                pc_we,
  output logic                ifid_we,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                exmem_we,
  output logic                md_start,
  output logic                md_busy,
  output logic [STALL_CW-1:0] stall_cnt
);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [MD_CW-1:0]  r_md_cnt;
  logic [MD_CW-1:0]  w_md_cnt_nxt;
  logic [STALL_CW-1:0] r_stall_cnt;
  logic              w_luh;

  pipe_hazard_ctrl_hazard_detect #(
    .RegAddrW (RegAddrW)
  ) u_hazard_detect (
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_ReadMem  (ex_ReadMem),
    .ex_WriteReg (ex_WriteReg),
    .ex_dest     (ex_dest),
    .o_luh       (w_luh)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= MD_IDLE;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!pc_we && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b0;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;

    if (rst) begin
      md_busy = (r_state == MD_BUSY);
      if (mem_stall) begin
        pc_we = 1'b0;
      end else if (br_taken) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (w_luh && (r_state != MD_DONE)) begin
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
      end else if ((r_state == MD_IDLE) && id_muldiv) begin
        md_start    = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
      end else if (r_state == MD_BUSY) begin
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        exmem_we = 1'b1;
      end

      // The mul/div unit keeps counting through memory waits; a taken branch
      // aborts it even when the stall masks the flush this cycle.
      case (r_state)
        MD_IDLE: begin
          if (md_start) begin
            w_state_nxt  = MD_BUSY;
            w_md_cnt_nxt = MD_CW'(MD_CYCLES - 2);
          end
        end
        MD_BUSY: begin
          if (br_taken) begin
            w_state_nxt = MD_IDLE;
          end else if (r_md_cnt == '0) begin
            w_state_nxt = MD_DONE;
          end else begin
            w_md_cnt_nxt = r_md_cnt - 1'b1;
          end
        end
        MD_DONE: begin
          if (br_taken || !mem_stall) begin
            w_state_nxt = MD_IDLE;
          end
        end
        default: w_state_nxt = MD_IDLE;
      endcase
    end
  end

  assign stall_cnt = rst ? r_stall_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed vectors with a queue-based output scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RAW = 5;
  localparam int SCW = 4;

  // Flag order: pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, md_start, md_busy
  localparam logic [6:0] F_RUN   = 7'b1100100;
  localparam logic [6:0] F_LUH   = 7'b0001100;
  localparam logic [6:0] F_START = 7'b0001110;
  localparam logic [6:0] F_BUSY  = 7'b0001101;
  localparam logic [6:0] F_BR    = 7'b1111100;
  localparam logic [6:0] F_BRBSY = 7'b1111101;
  localparam logic [6:0] F_MW    = 7'b0000000;
  localparam logic [6:0] F_MWBSY = 7'b0000001;
  localparam logic [6:0] F_RST   = 7'b0000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [RAW-1:0] id_rs_addr, id_rt_addr, ex_dest;
  logic           id_uses_rs, id_uses_rt, id_muldiv;
  logic           ex_ReadMem, ex_WriteReg, br_taken, mem_stall;
  logic           pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, md_start, md_busy;
  logic [SCW-1:0] stall_cnt;

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .RegAddrW  (RAW),
    .MD_CYCLES (4),
    .MD_CW     (6),
    .STALL_CW  (SCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_muldiv   (id_muldiv),
    .ex_ReadMem  (ex_ReadMem),
    .ex_WriteReg (ex_WriteReg),
    .ex_dest     (ex_dest),
    .br_taken    (br_taken),
    .mem_stall   (mem_stall),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_we    (exmem_we),
    .md_start    (md_start),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  // Monitor: outputs are valid every cycle; compare mid-cycle when an expectation is queued
  always @(negedge clk) begin
    logic [10:0] act;
    logic [10:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, md_start, md_busy, stall_cnt};
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL cycle_outputs check#%0d t=%0t: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                 n_checks, $time, act[10:4], act[3:0], exp[10:4], exp[3:0]);
      end
    end
  end

  task automatic tick(input logic [6:0] f, input logic [3:0] c);
    exp_q.push_back({f, c});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_addr = '0; id_rt_addr = '0; ex_dest = '0;
    id_uses_rs = 0;  id_uses_rt = 0;  id_muldiv = 0;
    ex_ReadMem = 0;  ex_WriteReg = 0; br_taken = 0; mem_stall = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;

    // Outputs held low under reset even with a mul/div and a branch presented
    id_muldiv = 1; br_taken = 1;
    tick(F_RST, 0);
    tick(F_RST, 0);
    rst = 1'b1; clear_inputs();
    tick(F_RUN, 0);

    // Load-use on rs, then on rt, then non-hazard variants
    ex_ReadMem = 1; ex_WriteReg = 1; ex_dest = 5; id_rs_addr = 5; id_uses_rs = 1;
    tick(F_LUH, 0);
    clear_inputs();
    tick(F_RUN, 1);
    ex_ReadMem = 1; ex_WriteReg = 1; ex_dest = 7; id_rt_addr = 7; id_uses_rt = 1;
    tick(F_LUH, 1);
    clear_inputs();
    tick(F_RUN, 2);
    ex_ReadMem = 1; ex_WriteReg = 1; ex_dest = 5; id_rs_addr = 5; id_uses_rs = 0;
    tick(F_RUN, 2);
    ex_dest = 0; id_rs_addr = 0; id_uses_rs = 1;
    tick(F_RUN, 2);
    ex_dest = 9; id_rs_addr = 9; ex_WriteReg = 0;
    tick(F_RUN, 2);
    clear_inputs();

    // Full mul/div: start, three busy, one done cycle without a second start
    id_muldiv = 1;
    tick(F_START, 2);
    tick(F_BUSY, 3);
    tick(F_BUSY, 4);
    tick(F_BUSY, 5);
    tick(F_RUN, 6);
    id_muldiv = 0;
    tick(F_RUN, 6);

    // Branch aborts mul/div in the second busy cycle
    id_muldiv = 1;
    tick(F_START, 6);
    tick(F_BUSY, 7);
    br_taken = 1;
    tick(F_BRBSY, 8);
    br_taken = 0; id_muldiv = 0;
    tick(F_RUN, 8);

    // Memory wait across the busy-to-done boundary; done held until stall clears
    id_muldiv = 1;
    tick(F_START, 8);
    tick(F_BUSY, 9);
    tick(F_BUSY, 10);
    mem_stall = 1;
    tick(F_MWBSY, 11);
    tick(F_MW, 12);
    tick(F_MW, 13);
    mem_stall = 0;
    tick(F_RUN, 14);
    id_muldiv = 0;
    tick(F_RUN, 14);

    // Counter saturates at all-ones
    ex_ReadMem = 1; ex_WriteReg = 1; ex_dest = 3; id_rt_addr = 3; id_uses_rt = 1;
    tick(F_LUH, 14);
    tick(F_LUH, 15);
    tick(F_LUH, 15);
    clear_inputs();

    // Reset mid-busy returns to idle with a cleared counter
    id_muldiv = 1;
    tick(F_START, 15);
    tick(F_BUSY, 15);
    rst = 1'b0;
    tick(F_RST, 0);
    rst = 1'b1; id_muldiv = 0;
    tick(F_RUN, 0);

    // Twenty memory-wait cycles saturate the counter at 15
    mem_stall = 1;
    for (int i = 0; i < 20; i++) begin
      tick(F_MW, (i > 15) ? 4'd15 : 4'(i));
    end
    mem_stall = 0;
    tick(F_RUN, 15);

    // Branch plus memory stall in busy: stall owns outputs, abort still happens
    id_muldiv = 1;
    tick(F_START, 15);
    tick(F_BUSY, 15);
    br_taken = 1; mem_stall = 1;
    tick(F_MWBSY, 15);
    br_taken = 0; mem_stall = 0; id_muldiv = 0;
    tick(F_RUN, 15);

    // Branch from idle flushes without a busy indication
    br_taken = 1;
    tick(F_BR, 15);
    clear_inputs();
    tick(F_RUN, 15);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the decode stage.
- Generates PC / IF-ID / EX-MEM write enables, the IF-ID flush and the ID-EX bubble.
- Covers three hazard sources: load-use interlock, taken-branch flush and data-memory wait.
- Also sequences the multi-cycle mul/div unit: start pulse, busy countdown, release of the held instruction.
- Keeps a saturating stall-cycle counter for performance observation.

Parameters:
- RegAddrW, 5, register address width.
- MD_CYCLES, 32, mul/div latency in cycles (must be >= 2).
- MD_CW, 6, mul/div countdown width (must hold MD_CYCLES-1).
- STALL_CW, 16, stall counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs_addr  in  RegAddrW  rs field of the instruction in ID.
- id_rt_addr  in  RegAddrW  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_muldiv  in  1  ID instruction is a mul/div.
- ex_ReadMem  in  1  EX instruction is a load.
- ex_WriteReg  in  1  EX instruction writes a register.
- ex_dest  in  RegAddrW  destination register of the EX instruction.
- br_taken  in  1  EX resolved a taken branch or jump.
- mem_stall  in  1  data memory not ready this cycle.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to a nop.
- idex_bubble  out  1  load a nop into ID/EX.
- exmem_we  out  1  EX/MEM and MEM/WB write enable.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_busy  out  1  mul/div in progress.
- stall_cnt  out  STALL_CW  count of cycles with pc_we=0.

Behaviour:
- State: FSM {IDLE, BUSY, DONE}, md_cnt, stall_cnt. All are cleared asynchronously by rst=0: state=IDLE, md_cnt=0, stall_cnt=0.
- While rst=0, every output is 0.
- Outputs are combinational from state and inputs. State updates on the clk rising edge.
- Load-use hazard: luh = ex_ReadMem & ex_WriteReg & ex_dest!=0 & ((id_uses_rs & id_rs_addr==ex_dest) | (id_uses_rt & id_rt_addr==ex_dest)).
- Output priority, highest first:
  1. mem_stall=1: pc_we=ifid_we=exmem_we=0; ifid_flush=idex_bubble=md_start=0. The FSM still advances as described below.
  2. br_taken=1: pc_we=ifid_we=exmem_we=1, ifid_flush=1, idex_bubble=1. If state is BUSY or DONE, next state is IDLE (the mul/div is abandoned); md_start=0.
  3. luh=1 (any state except DONE): pc_we=ifid_we=0, idex_bubble=1, exmem_we=1.
  4. IDLE & id_muldiv: md_start=1, pc_we=ifid_we=0, idex_bubble=1, exmem_we=1. Next: BUSY, md_cnt=MD_CYCLES-2.
  5. BUSY: pc_we=ifid_we=0, idex_bubble=1, exmem_we=1.
  6. Otherwise (including DONE): all enables 1, flush/bubble 0.
- BUSY transitions:
  - md_cnt decrements every cycle, including cycles with mem_stall=1 (the unit runs independently).
  - When md_cnt==0, next state is DONE.
- DONE transitions:
  - The held instruction issues to EX.
  - md_start is never asserted in DONE, even though id_muldiv is still 1.
  - DONE→IDLE on the first cycle with mem_stall=0; DONE is held while mem_stall=1.
- md_busy=1 iff state==BUSY.
- mul/div timing: md_start cycle plus MD_CYCLES-1 BUSY cycles, then one DONE cycle. The mul/div occupies ID for MD_CYCLES+1 cycles in total.
- stall_cnt increments when rst=1 and pc_we=0, and saturates at all-ones.
- md_start is asserted only when mem_stall=0, br_taken=0 and luh=0.
- Simultaneous br_taken and mem_stall: mem_stall wins the outputs. The FSM abort still happens, because the branch is re-presented by the held EX stage next cycle.

Decomposition:
- Add to the shared define package: RegAddrWidth and the FSM state encodings MD_IDLE=2'd0, MD_BUSY=2'd1, MD_DONE=2'd2.
- One natural sub-module: hazard_detect (combinational luh comparator).
- The FSM, counters and priority mux stay in pipe_hazard_ctrl.

Test Plan:
- Reset: rst=0 mid-BUSY, then released → state IDLE, md_busy=0, stall_cnt=0, all outputs 0 while rst=0.
- Load-use: ex_ReadMem=1, ex_WriteReg=1, ex_dest=5; id_rs_addr=5, id_uses_rs=1 → pc_we=0, ifid_we=0, idex_bubble=1 for exactly that cycle; stall_cnt +1.
- Same load-use case with ex_dest=0 → no stall.
- Mul/div, MD_CYCLES=4: id_muldiv=1 → md_start for 1 cycle, md_busy for 3 cycles, then a DONE cycle with pc_we=1; md_start pulses exactly once; stall_cnt +4.
- Branch abort: br_taken=1 during the second BUSY cycle → ifid_flush=1, idex_bubble=1, next state IDLE, md_busy=0.
- Memory wait: mem_stall=1 for 3 cycles spanning the BUSY→DONE boundary → all enables 0; FSM waits in DONE and exits on the first mem_stall=0 cycle.
- Saturation: STALL_CW=4, 20 stall cycles → stall_cnt=15.
